// File: rtl/soc_map_pkg.sv
// Shared SoC address map for the data-side responder: MMIO page base,
// register offsets inside the page and the data bus width.
package soc_map_pkg;
  localparam int unsigned DATA_W    = 32;
  localparam logic [31:0] MMIO_BASE = 32'hbfaf_f000;

  localparam logic [11:0] OFF_TIMER  = 12'h000;
  localparam logic [11:0] OFF_LED    = 12'h004;
  localparam logic [11:0] OFF_SWITCH = 12'h008;
  localparam logic [11:0] OFF_NUM    = 12'h00c;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:12] == MMIO_BASE[31:12];
  endfunction
endpackage

// File: rtl/sp_ram_rf.sv
// Single-port synchronous RAM, read-first, registered output.
// No reset on the array or the output so it maps onto block RAM.
module sp_ram_rf #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_sram_resp.sv
// CPU data SRAM responder: word RAM plus an MMIO page (timer, LED, switches,
// number display). Every edge is an access; read data returns one cycle later.
module data_sram_resp
  import soc_map_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  input  logic [7:0]        sw,
  output logic [15:0]       led,
  output logic [DATA_W-1:0] num_data
);
  logic              mmio_hit;
  logic [11:0]       off;
  logic              wr_mmio;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] mmio_rd;

  logic [DATA_W-1:0] timer_q, timer_d;
  logic [15:0]       led_q, led_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic [7:0]        sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0] mmio_rd_q;
  logic              hit_q;

  assign mmio_hit = is_mmio(data_sram_addr);
  assign off      = data_sram_addr[11:0];
  assign wr_mmio  = data_sram_we & mmio_hit;

  // Gating with resetn keeps a write that coincides with reset from landing.
  sp_ram_rf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .we_i    (data_sram_we & ~mmio_hit & resetn),
    .addr_i  (data_sram_addr[ADDR_W+1:2]),
    .wdata_i (data_sram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    timer_d = timer_q + 32'd1;
    led_d   = led_q;
    num_d   = num_q;
    if (wr_mmio) begin
      case (off)
        OFF_TIMER: timer_d = data_sram_wdata;
        OFF_LED:   led_d   = data_sram_wdata[15:0];
        OFF_NUM:   num_d   = data_sram_wdata;
        default: ;
      endcase
    end
  end

  // Read-first: the mux sees register values from before this edge's write.
  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_TIMER:  mmio_rd = timer_q;
      OFF_LED:    mmio_rd = {16'b0, led_q};
      OFF_SWITCH: mmio_rd = {24'b0, sw_sync_q};
      OFF_NUM:    mmio_rd = num_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= '0;
      led_q     <= '0;
      num_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      mmio_rd_q <= '0;
      hit_q     <= 1'b1; // selects the cleared MMIO path so rdata reads 0
    end else begin
      timer_q   <= timer_d;
      led_q     <= led_d;
      num_q     <= num_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      mmio_rd_q <= mmio_hit ? mmio_rd : '0;
      hit_q     <= mmio_hit;
    end
  end

  assign data_sram_rdata = hit_q ? mmio_rd_q : ram_rdata;
  assign led             = led_q;
  assign num_data        = num_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: stimulus pushes expected rdata per
// access, a monitor pops one entry per clock edge and compares.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  sw = '0;
  logic [15:0] led;
  logic [31:0] num_data;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] A_TIMER = 32'hbfaf_f000;
  localparam logic [31:0] A_LED   = 32'hbfaf_f004;
  localparam logic [31:0] A_SW    = 32'hbfaf_f008;
  localparam logic [31:0] A_NUM   = 32'hbfaf_f00c;
  localparam logic [31:0] A_HOLE  = 32'hbfaf_f020;

  data_sram_resp #(.ADDR_W(10)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .sw              (sw),
    .led             (led),
    .num_data        (num_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access sampled at the next rising edge; expected rdata queued.
  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    we = w; addr = a; wdata = d;
    e.chk = chk; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: rdata after edge N belongs to the access sampled at edge N.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) check(e.name, rdata, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'b0, led}, 32'h0);
    check("reset_num", num_data, 32'h0);

    @(negedge clk);
    resetn = 1'b1;
    we = 1'b0; addr = A_TIMER; wdata = '0;
    begin
      exp_t e;
      e.chk = 1'b1; e.exp = 32'h0; e.name = "timer_first";
      q.push_back(e);
    end
    acc(0, A_TIMER, 0, 1, 32'h1, "timer_second");

    acc(1, 32'h0000_0010, 32'hdead_beef, 0, 0, "ram_wr");
    acc(0, 32'h0000_0010, 0, 1, 32'hdead_beef, "ram_rd");
    acc(0, 32'h0000_1010, 0, 1, 32'hdead_beef, "ram_alias");

    acc(1, 32'h0000_0020, 32'h1111_1111, 0, 0, "rf_init");
    acc(1, 32'h0000_0020, 32'h2222_2222, 1, 32'h1111_1111, "read_first");
    acc(0, 32'h0000_0020, 0, 1, 32'h2222_2222, "rf_next");

    acc(1, A_LED, 32'h0001_a5a5, 1, 32'h0, "led_wr_old");
    acc(0, A_LED, 0, 1, 32'h0000_a5a5, "led_rd");
    check("led_port", {16'b0, led}, 32'h0000_a5a5);
    acc(1, A_NUM, 32'h1234_5678, 1, 32'h0, "num_wr_old");
    acc(0, A_HOLE, 0, 1, 32'h0, "hole_rd");
    check("num_port", num_data, 32'h1234_5678);
    acc(1, A_HOLE, 32'hffff_ffff, 1, 32'h0, "hole_wr");
    acc(0, A_HOLE, 0, 1, 32'h0, "hole_rd2");
    acc(1, A_SW, 32'h0000_00ff, 1, 32'h0, "sw_rd_zero");

    acc(1, A_TIMER, 32'hffff_fffe, 0, 0, "timer_load");
    acc(0, A_TIMER, 0, 1, 32'hffff_fffe, "timer_t0");
    acc(0, A_TIMER, 0, 1, 32'hffff_ffff, "timer_t1");
    acc(0, A_TIMER, 0, 1, 32'h0000_0000, "timer_wrap");

    acc(0, 32'h0000_0100, 0, 0, 0, "idle0");
    sw = 8'h5a;
    acc(0, 32'h0000_0100, 0, 0, 0, "idle1");
    acc(0, A_SW, 0, 1, 32'h0000_005a, "sw_rd");

    acc(0, A_NUM, 0, 1, 32'h1234_5678, "num_rd");
    we = 1'b0;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_led", {16'b0, led}, 32'h0);
    check("async_num", num_data, 32'h0);
    check("async_rdata", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    we = 1'b0; addr = A_LED;
    begin
      exp_t e;
      e.chk = 1'b1; e.exp = 32'h0; e.name = "post_reset_led";
      q.push_back(e);
    end
    acc(0, 32'h0000_0020, 0, 1, 32'h2222_2222, "ram_kept");
    acc(0, 32'h0000_0100, 0, 0, 0, "drain");
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d entries expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
